// File: rtl/seq_1001_gen.sv
// seq_1001_gen: serial frame burst generator.
// On start (sampled only in IDLE) the 4-bit pattern and the frame count are
// captured, then count+1 frames are shifted out MSB first on 'out', one bit
// per cycle. A one-cycle DONE state follows the last bit and pulses 'done'.
// Optional feature macro: SEQ_GEN_GAP_EN -- when defined, GAP_LEN idle zeros
// are inserted between consecutive frames (GAP state + gap counter). When
// undefined, frames are sent back-to-back and GAP_LEN has no effect.
//
// Handshake: 'start' is a single-cycle request honoured only when the FSM is
// in IDLE; it is ignored while busy=1 and in the DONE cycle. 'busy' is high
// for every cycle that carries frame or gap bits; 'done' is high for exactly
// one cycle after the final bit of a burst and never after a reset abort.
module seq_1001_gen #(
    parameter int GAP_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pattern,
    input  logic [3:0] count,
    output logic       out,
    output logic       busy,
    output logic       done
);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B3   = 3'd1,
        B2   = 3'd2,
        B1   = 3'd3,
        B0   = 3'd4,
        GAP  = 3'd5,
        DONE = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B3   = 3'd1,
        B2   = 3'd2,
        B1   = 3'd3,
        B0   = 3'd4,
        DONE = 3'd6
    } state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pat_q;     // captured frame bits
    logic [3:0] frames_q;  // frames remaining after the current one

`ifdef SEQ_GEN_GAP_EN
    logic [2:0] gap_q;     // gap cycles remaining after the current one
`else
    // GAP_LEN has no function without the gap feature.
    logic [2:0] unused_gap_len;
    assign unused_gap_len = 3'(GAP_LEN);
`endif

    // State register; reset returns to IDLE, which aborts any burst silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured pattern, frame counter and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q    <= 4'd0;
            frames_q <= 4'd0;
`ifdef SEQ_GEN_GAP_EN
            gap_q    <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q    <= pattern;
                        frames_q <= count;
                    end
                end
                B0: begin
                    // Counter stops at zero; zero marks the last frame.
                    if (frames_q != 4'd0) begin
                        frames_q <= frames_q - 4'd1;
`ifdef SEQ_GEN_GAP_EN
                        gap_q    <= 3'(GAP_LEN - 1);
`endif
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    if (gap_q != 3'd0) begin
                        gap_q <= gap_q - 3'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        state_nxt = state;
        out       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = B3;
            end
            B3: begin
                out       = pat_q[3];
                busy      = 1'b1;
                state_nxt = B2;
            end
            B2: begin
                out       = pat_q[2];
                busy      = 1'b1;
                state_nxt = B1;
            end
            B1: begin
                out       = pat_q[1];
                busy      = 1'b1;
                state_nxt = B0;
            end
            B0: begin
                out  = pat_q[0];
                busy = 1'b1;
                if (frames_q == 4'd0) begin
                    state_nxt = DONE;
                end else begin
`ifdef SEQ_GEN_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = B3;
`endif
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                busy = 1'b1;
                if (gap_q == 3'd0) state_nxt = B3;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_1001_gen.sv
// tb_seq_1001_gen: directed bench for seq_1001_gen.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seq_1001_gen;

    localparam int GAP_LEN = 2;
`ifdef SEQ_GEN_GAP_EN
    localparam int GAP_CYC     = GAP_LEN;
`else
    localparam int GAP_CYC     = 0;
`endif
    // Cycle (1-based after the start edge) holding B2 of frame 2.
    localparam int B2_F2_CYCLE = 6 + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] count;
    logic       out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {out, busy, done} per cycle.
    logic [2:0] exp_q[$];

    // Free-running monitors, sampled on the falling edge.
    logic [3:0]  det_sr    = 4'd0;
    int          det_hits  = 0;
    int          done_cnt  = 0;
    int          ones_cnt  = 0;
    int          busy_cnt  = 0;
    logic [15:0] stream    = 16'd0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_1001_gen #(.GAP_LEN(GAP_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .count   (count),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    // Non-overlapping 1001 detector plus event counters.
    always @(negedge clk) begin
        if ({det_sr[2:0], out} == 4'b1001) begin
            det_hits = det_hits + 1;
            det_sr   = 4'd0;
        end else begin
            det_sr = {det_sr[2:0], out};
        end
        if (done) done_cnt = done_cnt + 1;
        if (out)  ones_cnt = ones_cnt + 1;
        if (busy) begin
            busy_cnt = busy_cnt + 1;
            stream   = {stream[14:0], out};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] p, input logic [3:0] c);
        pattern = p;
        count   = c;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    // Expected cycles of one burst: frame bits, optional gaps, then DONE.
    task automatic push_burst(input logic [3:0] p, input logic [3:0] c);
        for (int f = 0; f <= int'(c); f++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b0});
            if (f < int'(c))
                for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b001);
    endtask

    // Compare n queued cycles (all when n < 0), advancing one cycle each.
    task automatic drain(input string tag, input int n);
        logic [2:0] e;
        int k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, k), {29'd0, out, busy, done}, {29'd0, e});
            cyc();
            k++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int det0, done0, ones0, busy0;
        rst     = 1'b1;
        start   = 1'b0;
        pattern = 4'd0;
        count   = 4'd0;
        repeat (3) cyc();

        // Reset state, with start held to confirm reset priority.
        start = 1'b1;
        cyc();
        check("rst_out",  {31'd0, out},  32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        cyc();
        check("idle_hold", {29'd0, out, busy, done}, 32'd0);

        // Single frame: 1,0,0,1 in cycles 1-4, done in cycle 5, then idle.
        do_start(4'b1001, 4'd0);
        exp_q = '{3'b110, 3'b010, 3'b010, 3'b110, 3'b001, 3'b000};
        drain("single", -1);

        // Three-frame burst.
        det0  = det_hits;
        done0 = done_cnt;
        do_start(4'b1001, 4'd2);
        push_burst(4'b1001, 4'd2);
        drain("burst", -1);
`ifdef SEQ_GEN_GAP_EN
        check("burst_stream", {16'd0, stream}, {16'd0, 16'b1001001001001001});
`else
        check("burst_stream", {20'd0, stream[11:0]}, {20'd0, 12'b100110011001});
`endif
        check("burst_det",  det_hits - det0,  3);
        check("burst_done", done_cnt - done0, 1);

        // Reset during B2 of frame 2, then restart on the first edge.
        done0 = done_cnt;
        do_start(4'b1001, 4'd2);
        repeat (B2_F2_CYCLE - 1) cyc();
        check("abort_pre", {29'd0, out, busy, done}, {29'd0, 3'b010});
        rst = 1'b1;
        cyc();
        check("abort_post", {29'd0, out, busy, done}, 32'd0);
        rst = 1'b0;
        check("abort_nodone", done_cnt - done0, 0);
        do_start(4'b1001, 4'd0);
        exp_q = '{3'b110, 3'b010, 3'b010, 3'b110, 3'b001};
        drain("restart", -1);
        check("restart_done", done_cnt - done0, 1);

        // Start and new inputs during B1 are ignored; start in DONE ignored.
        cyc();
        do_start(4'b1001, 4'd1);
        push_burst(4'b1001, 4'd1);
        drain("ign", 2);
        start   = 1'b1;
        pattern = 4'b0110;
        count   = 4'd15;
        cyc();
        start   = 1'b0;
        check("ign_b0", {29'd0, out, busy, done}, {29'd0, 3'b110});
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cyc();
        drain("ign_rest", exp_q.size() - 1);
        check("ign_done", {29'd0, out, busy, done}, {29'd0, 3'b001});
        void'(exp_q.pop_front());
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("ign_after_done0", {29'd0, out, busy, done}, 32'd0);
        cyc();
        check("ign_after_done1", {29'd0, out, busy, done}, 32'd0);

        // Maximum burst: 16 frames of 1111.
        done0 = done_cnt;
        ones0 = ones_cnt;
        busy0 = busy_cnt;
        do_start(4'b1111, 4'd15);
        push_burst(4'b1111, 4'd15);
        drain("max", -1);
        check("max_ones", ones_cnt - ones0, 64);
        check("max_busy", busy_cnt - busy0, 64 + 15 * GAP_CYC);
        check("max_done", done_cnt - done0, 1);
        repeat (4) cyc();
        check("max_quiet", {29'd0, out, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_1001_gen.md
SEQ_1001_GEN -- requirements
Module: seq_1001_gen

Interface
REQ-001 The module SHALL have parameter GAP_LEN, default 2, giving the number of idle 0 bits inserted between consecutive frames (used only when SEQ_GEN_GAP_EN is defined; legal range 1..7).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, a request to begin a burst, sampled only in IDLE.
REQ-005 The module SHALL have port pattern, input, 4 bits, the frame bits, transmitted MSB first; default use is 4'b1001.
REQ-006 The module SHALL have port count, input, 4 bits, the burst length, where the number of frames is count+1 (1..16).
REQ-007 The module SHALL have port out, output, 1 bit, the serial bit stream (Moore output, decoded from the registered state only).
REQ-008 The module SHALL have port busy, output, 1 bit, high while a burst is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit of a burst.

Function
REQ-010 The FSM SHALL have states IDLE, B3, B2, B1, B0, GAP (present only with SEQ_GEN_GAP_EN) and DONE.
REQ-011 In IDLE with start=1 at an edge, the module SHALL capture pattern and count into internal registers and enter B3.
REQ-012 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-013 Each state Bn SHALL last exactly one cycle with out = captured pattern[n], in the order B3->B2->B1->B0.
REQ-014 Latency: the first bit SHALL appear on out in the cycle immediately after the start-sampling edge.
REQ-015 From B0, if frames remain, the FSM SHALL go to B3 (macro off) or GAP (macro on), decrementing the remaining-frame counter.
REQ-016 From B0 on the last frame, the FSM SHALL go to DONE.
REQ-017 GAP SHALL last exactly GAP_LEN cycles with out=0, using an internal gap counter, then go to B3.
REQ-018 DONE SHALL last one cycle with out=0, done=1 and busy=0, then go to IDLE unconditionally.
REQ-019 A start asserted in DONE SHALL be ignored, so the minimum spacing between bursts is one IDLE cycle.
REQ-020 busy SHALL be 1 in B3, B2, B1, B0 and GAP, and 0 in IDLE and DONE.
REQ-021 out SHALL be 0 in IDLE, GAP and DONE.
REQ-022 start asserted while busy=1 SHALL be ignored and SHALL NOT restart or extend the burst.
REQ-023 Changes on pattern or count while busy=1 SHALL NOT affect the current burst; only the captured copies are used.
REQ-024 The remaining-frame counter SHALL be 4 bits, loaded with count and decremented in B0, with the last frame detected at value 0 and no wrap-around.
REQ-025 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 When rst=1 at a rising edge, the module SHALL force state=IDLE, out=0, busy=0, done=0, and clear the frame and gap counters and the captured pattern.
REQ-027 rst SHALL take priority over start, and reset asserted mid-frame SHALL abort the burst with no done pulse.
REQ-028 After rst deasserts, the module SHALL accept a new start on the first edge.

Configuration
REQ-029 With macro SEQ_GEN_GAP_EN defined, the GAP state and gap counter SHALL be compiled in, and frames SHALL be separated by GAP_LEN zeros.
REQ-030 Without SEQ_GEN_GAP_EN, the GAP state and gap counter SHALL be absent, frames SHALL be sent back-to-back, and GAP_LEN SHALL be ignored.

Verification
REQ-031 Single frame: pattern=1001, count=0, start pulsed -> out=1,0,0,1 in cycles 1-4, done=1 in cycle 5, busy=1 only in cycles 1-4.
REQ-032 Burst without the macro: pattern=1001, count=2 -> out=100110011001 (12 cycles), done in cycle 13; a 1001 detector sampling on the falling edge fires 3 times (non-overlap counted at each frame end).
REQ-033 Burst with SEQ_GEN_GAP_EN and GAP_LEN=2: pattern=1001, count=2 -> out=1001 00 1001 00 1001 (16 cycles), done in cycle 17.
REQ-034 Reset mid-burst: rst=1 during B2 of frame 2 -> next cycle out=0, busy=0, and no done pulse occurs.
REQ-035 Ignored inputs: start pulsed and pattern changed to 0110 during B1 -> the burst is unchanged; start in the DONE cycle -> no new burst.
REQ-036 Maximum burst: count=15, pattern=1111 -> 16 frames (64 ones with the macro off), done exactly once, with no counter wrap.
